// File: rtl/stream_fifo.sv
`default_nettype none
// ============================================================================
// stream_fifo : first-word-fall-through FIFO with valid/ready on both sides.
// Revision    : 1.0
// ============================================================================
module stream_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     flush_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [WIDTH-1:0]         in_data_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [WIDTH-1:0]         out_data_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (WIDTH < 1) begin : g_bad_width
        $error("stream_fifo: WIDTH must be at least 1");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("stream_fifo: DEPTH must be a power of two and >= 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      wr_ptr_nxt;
    logic [AW:0]      rd_ptr_nxt;
    logic [AW:0]      level_nxt;
    logic             push;
    logic             pop;
    logic             head_load;
    logic [WIDTH-1:0] head_nxt;

    always_comb begin
        push       = in_valid_i & in_ready_o;
        pop        = out_valid_o & out_ready_i;
        wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, push};
        rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, pop};
        level_nxt  = wr_ptr_nxt - rd_ptr_nxt;
        // The head register reloads only when the current head leaves or none
        // is shown yet; a word being written this cycle is forwarded from the input.
        head_load  = (level_nxt != '0) && (pop || !out_valid_o);
        head_nxt   = (rd_ptr_nxt == wr_ptr) ? in_data_i : mem[rd_ptr_nxt[AW-1:0]];
    end

    always_ff @(posedge clk_i) begin
        if (push && !flush_i) begin
            mem[wr_ptr[AW-1:0]] <= in_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level_o     <= '0;
            out_valid_o <= 1'b0;
            in_ready_o  <= 1'b0;
            out_data_o  <= '0;
        end else if (flush_i) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level_o     <= '0;
            out_valid_o <= 1'b0;
            in_ready_o  <= 1'b1;
        end else begin
            wr_ptr      <= wr_ptr_nxt;
            rd_ptr      <= rd_ptr_nxt;
            level_o     <= level_nxt;
            out_valid_o <= (level_nxt != '0);
            // level never exceeds DEPTH = 2**AW, so the top bit alone marks full
            in_ready_o  <= !level_nxt[AW];
            if (head_load) begin
                out_data_o <= head_nxt;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stream_fifo.sv
`default_nettype none
// ============================================================================
// tb_stream_fifo : directed self-checking bench for stream_fifo (8 x 4).
// Revision       : 1.0
// ============================================================================
module tb_stream_fifo;

    logic       clk_i = 1'b0;
    logic       rstn_i;
    logic       flush_i;
    logic       in_valid_i;
    logic       in_ready_o;
    logic [7:0] in_data_i;
    logic       out_valid_o;
    logic       out_ready_i;
    logic [7:0] out_data_o;
    logic [2:0] level_o;

    int tests = 0;
    int fails = 0;

    stream_fifo #(.WIDTH(8), .DEPTH(4)) dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .level_o     (level_o)
    );

    always #5 clk_i = ~clk_i;

    // Observed state packed as {in_ready, out_valid, level, out_data}
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        logic [12:0] exp;
        rstn_i = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0;
        out_ready_i = 1'b0; in_data_i = 8'h00;
        #1;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp = {1'b0, 1'b0, 3'd0, 8'h00};
            tests++;
            if ({in_ready_o, out_valid_o, level_o, out_data_o} !== exp) begin
                fails++;
                $display("FAIL reset_hold[%0d] got %h expected %h", i,
                         {in_ready_o, out_valid_o, level_o, out_data_o}, exp);
            end
        end
        rstn_i = 1'b1;
        tick();
        exp = {1'b1, 1'b0, 3'd0, 8'h00};
        tests++;
        if ({in_ready_o, out_valid_o, level_o, out_data_o} !== exp) begin
            fails++;
            $display("FAIL reset_release got %h expected %h",
                     {in_ready_o, out_valid_o, level_o, out_data_o}, exp);
        end
        out_ready_i = 1'b1;
        tick();
        tick();
        out_ready_i = 1'b0;
        tests++;
        if ({in_ready_o, out_valid_o, level_o, out_data_o} !== exp) begin
            fails++;
            $display("FAIL empty_pop_ignored got %h expected %h",
                     {in_ready_o, out_valid_o, level_o, out_data_o}, exp);
        end
    endtask

    task automatic test_fill_drain();
        logic [7:0] words [5];
        words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data_i = words[i];
            tick();
            tests++;
            // head is always 0x11; level saturates at 4 and ready drops at 4
            if ({in_ready_o, out_valid_o, level_o, out_data_o} !==
                {(i < 3), 1'b1, (i < 4) ? 3'(i + 1) : 3'd4, 8'h11}) begin
                fails++;
                $display("FAIL fill[%0d] got rdy=%b vld=%b lvl=%0d data=%h expected lvl=%0d",
                         i, in_ready_o, out_valid_o, level_o, out_data_o, (i < 4) ? i + 1 : 4);
            end
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        for (int i = 1; i < 4; i++) begin
            tick();
            tests++;
            if ({out_valid_o, level_o, out_data_o} !== {1'b1, 3'(4 - i), words[i]}) begin
                fails++;
                $display("FAIL drain[%0d] got vld=%b lvl=%0d data=%h expected lvl=%0d data=%h",
                         i, out_valid_o, level_o, out_data_o, 4 - i, words[i]);
            end
        end
        tick();
        out_ready_i = 1'b0;
        tests++;
        if ({in_ready_o, out_valid_o, level_o, out_data_o} !== {1'b1, 1'b0, 3'd0, 8'h44}) begin
            fails++;
            $display("FAIL drain_empty got vld=%b lvl=%0d data=%h expected vld=0 lvl=0 data=44",
                     out_valid_o, level_o, out_data_o);
        end
    endtask

    task automatic test_stream();
        in_valid_i  = 1'b1;
        out_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data_i = 8'(i);
            tick();
            tests++;
            if ({in_ready_o, out_valid_o, level_o, out_data_o} !== {1'b1, 1'b1, 3'd1, 8'(i)}) begin
                fails++;
                $display("FAIL stream[%0d] got rdy=%b vld=%b lvl=%0d data=%h expected data=%h lvl=1",
                         i, in_ready_o, out_valid_o, level_o, out_data_o, i);
            end
        end
        in_valid_i = 1'b0;
        tick();
        out_ready_i = 1'b0;
        tests++;
        if ({out_valid_o, level_o} !== {1'b0, 3'd0}) begin
            fails++;
            $display("FAIL stream_end got vld=%b lvl=%0d expected vld=0 lvl=0",
                     out_valid_o, level_o);
        end
    endtask

    task automatic test_full_pop();
        logic [7:0] exp_q [4];
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data_i = 8'hA0 + 8'(i);
            tick();
        end
        tests++;
        if ({in_ready_o, level_o, out_data_o} !== {1'b0, 3'd4, 8'hA0}) begin
            fails++;
            $display("FAIL fullpop_full got rdy=%b lvl=%0d data=%h expected rdy=0 lvl=4 data=a0",
                     in_ready_o, level_o, out_data_o);
        end
        in_data_i   = 8'hB0;
        out_ready_i = 1'b1;
        tick();
        tests++;
        if ({in_ready_o, level_o, out_data_o} !== {1'b1, 3'd3, 8'hA1}) begin
            fails++;
            $display("FAIL fullpop_nopush got rdy=%b lvl=%0d data=%h expected rdy=1 lvl=3 data=a1",
                     in_ready_o, level_o, out_data_o);
        end
        out_ready_i = 1'b0;
        tick();
        in_valid_i = 1'b0;
        tests++;
        if ({in_ready_o, level_o, out_data_o} !== {1'b0, 3'd4, 8'hA1}) begin
            fails++;
            $display("FAIL fullpop_push got rdy=%b lvl=%0d data=%h expected rdy=0 lvl=4 data=a1",
                     in_ready_o, level_o, out_data_o);
        end
        exp_q = '{8'hA2, 8'hA3, 8'hB0, 8'hB0};
        out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if ({out_valid_o, out_data_o} !== {1'b1, exp_q[i]}) begin
                fails++;
                $display("FAIL fullpop_order[%0d] got vld=%b data=%h expected %h",
                         i, out_valid_o, out_data_o, exp_q[i]);
            end
        end
        tick();
        out_ready_i = 1'b0;
        tests++;
        if ({out_valid_o, level_o} !== {1'b0, 3'd0}) begin
            fails++;
            $display("FAIL fullpop_empty got vld=%b lvl=%0d expected vld=0 lvl=0",
                     out_valid_o, level_o);
        end
    endtask

    task automatic test_flush();
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        in_data_i   = 8'hC0; tick();
        in_data_i   = 8'hC1; tick();
        flush_i     = 1'b1;
        in_data_i   = 8'hAA;
        out_ready_i = 1'b1;
        tick();
        flush_i     = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        tests++;
        if ({in_ready_o, out_valid_o, level_o, out_data_o} !== {1'b1, 1'b0, 3'd0, 8'hC0}) begin
            fails++;
            $display("FAIL flush got rdy=%b vld=%b lvl=%0d data=%h expected rdy=1 vld=0 lvl=0 data=c0",
                     in_ready_o, out_valid_o, level_o, out_data_o);
        end
        tick();
        in_valid_i = 1'b1;
        in_data_i  = 8'hD0;
        tick();
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        tests++;
        if ({out_valid_o, level_o, out_data_o} !== {1'b1, 3'd1, 8'hD0}) begin
            fails++;
            $display("FAIL flush_after got vld=%b lvl=%0d data=%h expected vld=1 lvl=1 data=d0",
                     out_valid_o, level_o, out_data_o);
        end
        tick();
        out_ready_i = 1'b0;
    endtask

    task automatic test_async_reset();
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data_i = 8'hE0 + 8'(i);
            tick();
        end
        tests++;
        if (level_o !== 3'd3) begin
            fails++;
            $display("FAIL areset_pre got lvl=%0d expected 3", level_o);
        end
        #2;
        rstn_i = 1'b0;
        #1;
        tests++;
        if ({in_ready_o, out_valid_o, level_o, out_data_o} !== 13'h0) begin
            fails++;
            $display("FAIL areset_immediate got rdy=%b vld=%b lvl=%0d data=%h expected all zero",
                     in_ready_o, out_valid_o, level_o, out_data_o);
        end
        in_valid_i = 1'b0;
        tick();
        #2;
        rstn_i = 1'b1;
        tick();
        tests++;
        if ({in_ready_o, out_valid_o, level_o} !== {1'b1, 1'b0, 3'd0}) begin
            fails++;
            $display("FAIL areset_release got rdy=%b vld=%b lvl=%0d expected rdy=1 vld=0 lvl=0",
                     in_ready_o, out_valid_o, level_o);
        end
        in_valid_i = 1'b1;
        in_data_i  = 8'hF0;
        tick();
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        tests++;
        if ({out_valid_o, level_o, out_data_o} !== {1'b1, 3'd1, 8'hF0}) begin
            fails++;
            $display("FAIL areset_after got vld=%b lvl=%0d data=%h expected vld=1 lvl=1 data=f0",
                     out_valid_o, level_o, out_data_o);
        end
        tick();
        out_ready_i = 1'b0;
        tests++;
        if ({out_valid_o, level_o} !== {1'b0, 3'd0}) begin
            fails++;
            $display("FAIL areset_drain got vld=%b lvl=%0d expected vld=0 lvl=0",
                     out_valid_o, level_o);
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_stream();
        test_full_pop();
        test_flush();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
